// File: rtl/ob_seq_pkg.sv
// ---------------------------------------------------------------------------
// ob_seq_pkg
// Shared definitions for the pipelined OB sequential reference block.
//   OB_CNT_W_DEFAULT : default width of the accepted-transaction counter
//   OB_MISR_TAPS     : MISR feedback tap mask used when WIDTH = 8
//   ob_logic()       : per-lane OB function, returns {o0, o1}
// ---------------------------------------------------------------------------
package ob_seq_pkg;

    localparam int         OB_CNT_W_DEFAULT = 16;
    localparam logic [7:0] OB_MISR_TAPS     = 8'hB8;

    // One lane of the original two-output OB circuit.
    function automatic logic [1:0] ob_logic(input logic i0, input logic i1);
        return {(i1 & ~i0) | i0, ~i1};
    endfunction

endpackage

// File: rtl/ob_pipe_stage.sv
// ---------------------------------------------------------------------------
// ob_pipe_stage
// One valid/data register of the OB pipeline with its stall logic.
// The stage loads whenever it is empty or its content is being taken by the
// downstream side in the same cycle.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   up_valid   in   upstream holds a valid word
//   up_data    in   upstream word
//   down_load  in   downstream takes this stage's content this cycle
//   load       out  this stage captures the upstream side this cycle
//   valid      out  stage holds a valid word (registered)
//   data       out  stage word (registered)
// ---------------------------------------------------------------------------
module ob_pipe_stage
    import ob_seq_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    input  logic          down_load,
    output logic          load,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;

    always_comb begin
        load    = ~valid_q | down_load;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = up_valid;
            // Bubbles do not disturb the held word.
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/ob_seq_pipe.sv
// ---------------------------------------------------------------------------
// ob_seq_pipe
// Pipelined, parametrised OB circuit: o0 = (i1 & ~i0) | i0, o1 = ~i1 per
// lane, computed at the input and carried through DEPTH registered stages
// with a valid/ready handshake. Counts accepted input transfers.
// Optional feature: define OB_SEQ_MISR_EN to build a WIDTH-bit MISR over
// (o0 ^ o1) of every output transfer on port sig; otherwise sig is 0.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   i0/i1 carry a valid operand pair
//   in_ready   out  an operand pair can be accepted this cycle
//   i0, i1     in   operands, WIDTH bits
//   out_valid  out  o0/o1 hold a valid result
//   out_ready  in   sink accepts the result this cycle
//   o0, o1     out  registered results, WIDTH bits
//   tx_count   out  accepted input transfers, wraps at 2^CNT_W
//   sig        out  output signature, WIDTH bits
// ---------------------------------------------------------------------------
module ob_seq_pipe
    import ob_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = OB_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [CNT_W-1:0] tx_count,
    output logic [WIDTH-1:0] sig
);

    localparam int DW = 2 * WIDTH;

    // ---------------- input-side combinational logic ----------------
    logic [WIDTH-1:0] o0_comb;
    logic [WIDTH-1:0] o1_comb;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign {o0_comb[gi], o1_comb[gi]} = ob_logic(i0[gi], i1[gi]);
        end
    endgenerate

    // ---------------- pipeline ----------------
    // Index 0 is the input side; indices 1..DEPTH are the stages.
    logic [DEPTH:0]  stg_valid;
    logic [DW-1:0]   stg_data [0:DEPTH];
    logic [DEPTH:1]  stg_load;
    logic [DEPTH:1]  stg_down;

    assign stg_valid[0] = in_valid;
    assign stg_data[0]  = {o0_comb, o1_comb};

    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
            // Stage gi is drained when some stage downstream of it has a free
            // slot or the sink accepts. Written in closed form from the stage
            // valids so the ready path is a flat AND/OR, not a ripple chain.
            if (gi == DEPTH) begin : g_last
                assign stg_down[gi] = out_ready;
            end else begin : g_mid
                assign stg_down[gi] = out_ready | ~(&stg_valid[DEPTH:gi+1]);
            end

            ob_pipe_stage #(
                .DW (DW)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .up_valid  (stg_valid[gi-1]),
                .up_data   (stg_data[gi-1]),
                .down_load (stg_down[gi]),
                .load      (stg_load[gi]),
                .valid     (stg_valid[gi]),
                .data      (stg_data[gi])
            );
        end
    endgenerate

    assign in_ready  = stg_load[1];
    assign out_valid = stg_valid[DEPTH];
    assign o0        = stg_data[DEPTH][DW-1:WIDTH];
    assign o1        = stg_data[DEPTH][WIDTH-1:0];

    // ---------------- transaction counter ----------------
    logic [CNT_W-1:0] tx_count_q;
    logic [CNT_W-1:0] tx_count_d;

    always_comb begin
        tx_count_d = tx_count_q;
        if (in_valid && in_ready) begin
            tx_count_d = tx_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count_q <= '0;
        end else begin
            tx_count_q <= tx_count_d;
        end
    end

    assign tx_count = tx_count_q;

    // ---------------- output signature ----------------
`ifdef OB_SEQ_MISR_EN
    // The package mask is defined for 8 lanes; other widths feed back from
    // the top bit only.
    function automatic logic [WIDTH-1:0] misr_taps();
        logic [WIDTH-1:0] t;
        t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (WIDTH == 8) begin
                t[i] = OB_MISR_TAPS[i % 8];
            end
        end
        if (WIDTH != 8) begin
            t[WIDTH-1] = 1'b1;
        end
        return t;
    endfunction

    localparam logic [WIDTH-1:0] MISR_TAPS = misr_taps();

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] misr_shift;
    logic             misr_fb;

    assign misr_fb = ^(sig_q & MISR_TAPS);

    generate
        if (WIDTH == 1) begin : g_misr_1
            assign misr_shift = misr_fb;
        end else begin : g_misr_n
            assign misr_shift = {sig_q[WIDTH-2:0], misr_fb};
        end
    endgenerate

    always_comb begin
        sig_d = sig_q;
        if (out_valid && out_ready) begin
            sig_d = misr_shift ^ (o0 ^ o1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_ob_seq_pipe.sv
module tb_ob_seq_pipe;

    localparam int W = 8;
    localparam int D = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o0;
    logic [W-1:0] o1;
    logic [15:0]  tx_count;
    logic [W-1:0] sig;

    // Narrow-counter copy sharing all inputs, used for the wrap check.
    logic         in_ready_w;
    logic         out_valid_w;
    logic [W-1:0] o0_w;
    logic [W-1:0] o1_w;
    logic [3:0]   tx_count_w;
    logic [W-1:0] sig_w;

    ob_seq_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .i0(i0), .i1(i1), .out_valid(out_valid), .out_ready(out_ready),
        .o0(o0), .o1(o1), .tx_count(tx_count), .sig(sig)
    );

    ob_seq_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .i0(i0), .i1(i1), .out_valid(out_valid_w), .out_ready(out_ready),
        .o0(o0_w), .o1(o1_w), .tx_count(tx_count_w), .sig(sig_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO of expected {o0, o1}, transfer count, signature.
    logic [2*W-1:0] model_q[$];
    int             model_tx;
    logic [W-1:0]   misr_m;

    task automatic model_reset();
        model_q.delete();
        model_tx = 0;
        misr_m   = '0;
    endtask

    // Drive one cycle (called at a negedge), record handshakes into the model
    // and report what left the pipe together with what should have left.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ordy, output logic acc, output logic emit,
                        output logic [2*W-1:0] got, output logic [2*W-1:0] exp);
        in_valid  = iv;
        i0        = a;
        i1        = b;
        out_ready = ordy;
        #1;
        acc  = in_valid & in_ready;
        emit = out_valid & out_ready;
        got  = {o0, o1};
        exp  = 'x;
        if (emit) begin
            if (model_q.size() > 0) begin
                exp = model_q.pop_front();
                misr_m = {misr_m[W-2:0], ^(misr_m & 8'hB8)} ^ (exp[2*W-1:W] ^ exp[W-1:0]);
            end
        end
        if (acc) begin
            // o0 = (i1 & ~i0) | i0 simplifies to i0 | i1.
            model_q.push_back({a | b, ~b});
            model_tx++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic acc, emit;
        logic [2*W-1:0] got, exp;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || o0 !== 8'h00 || o1 !== 8'h00 || tx_count !== 16'd0 || sig !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got out_valid=%b o0=%h o1=%h tx=%0d sig=%h, want 0/00/00/0/00",
                     out_valid, o0, o1, tx_count, sig);
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        // Fill the pipe, then reset asynchronously in mid-cycle.
        for (int k = 0; k < D; k++) step(1'b1, 8'($urandom), 8'($urandom), 1'b0, acc, emit, got, exp);
        checks++;
        if (out_valid !== 1'b1 || tx_count !== 16'(D)) begin
            errors++;
            $display("FAIL reset_prefill: got out_valid=%b tx=%0d want 1/%0d", out_valid, tx_count, D);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || o0 !== 8'h00 || o1 !== 8'h00 || tx_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: got out_valid=%b o0=%h o1=%h tx=%0d want 0/00/00/0",
                     out_valid, o0, o1, tx_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1, acc, emit, got, exp);
            checks++;
            if (emit !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_no_replay: cycle %0d got out_valid=%b in_ready=%b want 0/1", k, out_valid, in_ready);
            end
        end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_latency();
        logic acc, emit;
        logic [2*W-1:0] got, exp;
        int lat;
        do_reset();
        step(1'b1, 8'h0F, 8'h3C, 1'b1, acc, emit, got, exp);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            step(1'b0, 8'h00, 8'h00, 1'b1, acc, emit, got, exp);
            lat++;
        end
        checks++;
        if (lat != D || o0 !== 8'h3F || o1 !== 8'hC3) begin
            errors++;
            $display("FAIL latency: got lat=%0d o0=%h o1=%h want lat=%0d o0=3f o1=c3", lat, o0, o1, D);
        end
        step(1'b0, 8'h00, 8'h00, 1'b1, acc, emit, got, exp);
        checks++;
        if (emit !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL latency_emit: got emit=%b data=%h want 1/%h", emit, got, exp);
        end
        $display("test_latency done: lat=%0d errors=%0d", lat, errors);
    endtask

    task automatic test_stall();
        logic acc, emit;
        logic [2*W-1:0] got, exp, held;
        logic [W-1:0] a[3];
        logic [W-1:0] b[3];
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a[k] = 8'($urandom);
            b[k] = 8'($urandom);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, a[k], b[k], 1'b0, acc, emit, got, exp);
            checks++;
            if (acc !== (k < D)) begin
                errors++;
                $display("FAIL stall_accept: pair %0d got acc=%b want %b", k, acc, (k < D));
            end
        end
        held = {o0, o1};
        checks++;
        if (out_valid !== 1'b1 || held !== {a[0] | b[0], ~b[0]}) begin
            errors++;
            $display("FAIL stall_head: got valid=%b data=%h want 1/%h", out_valid, held, {a[0] | b[0], ~b[0]});
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, a[2], b[2], 1'b0, acc, emit, got, exp);
            checks++;
            if (acc !== 1'b0 || out_valid !== 1'b1 || {o0, o1} !== held) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got acc=%b valid=%b data=%h want 0/1/%h", k, acc, out_valid, {o0, o1}, held);
            end
        end
        // Full pipe, sink ready, source valid: accept and emit together.
        step(1'b1, a[2], b[2], 1'b1, acc, emit, got, exp);
        checks++;
        if (acc !== 1'b1 || emit !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL stall_release: got acc=%b emit=%b data=%h want 1/1/%h", acc, emit, got, exp);
        end
        for (int k = 0; k < D; k++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1, acc, emit, got, exp);
            checks++;
            if (emit !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL stall_drain: cycle %0d got emit=%b data=%h want 1/%h", k, emit, got, exp);
            end
        end
        checks++;
        if (out_valid !== 1'b0 || model_q.size() != 0) begin
            errors++;
            $display("FAIL stall_empty: got out_valid=%b pending=%0d want 0/0", out_valid, model_q.size());
        end
        $display("test_stall done: errors=%0d", errors);
    endtask

    task automatic test_streaming();
        logic acc, emit;
        logic [2*W-1:0] got, exp;
        int emits, first, last;
        do_reset();
        emits = 0;
        first = -1;
        last  = -1;
        for (int c = 0; c < 100 + D + 4; c++) begin
            step(c < 100, 8'($urandom), 8'($urandom), 1'b1, acc, emit, got, exp);
            if (c < 100 && acc !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL stream_ready: cycle %0d got in_ready=0 want 1", c);
            end
            if (emit) begin
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL stream_data: cycle %0d got %h want %h", c, got, exp);
                end
                emits++;
                if (first < 0) first = c;
                last = c;
            end
        end
        checks++;
        if (emits != 100 || first != D || last - first != 99 || tx_count !== 16'd100) begin
            errors++;
            $display("FAIL stream_summary: got emits=%0d first=%0d span=%0d tx=%0d want 100/%0d/99/100",
                     emits, first, last - first, tx_count, D);
        end
        $display("test_streaming done: emits=%0d errors=%0d", emits, errors);
    endtask

    task automatic test_random();
        logic acc, emit;
        logic [2*W-1:0] got, exp;
        int guard;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), $urandom_range(0, 2) != 0,
                 acc, emit, got, exp);
            if (emit) begin
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random_data: cycle %0d got %h want %h", c, got, exp);
                end
            end
        end
        guard = 0;
        while ((model_q.size() != 0 || out_valid === 1'b1) && guard < 50) begin
            step(1'b0, 8'h00, 8'h00, 1'b1, acc, emit, got, exp);
            guard++;
            if (emit) begin
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random_drain: got %h want %h", got, exp);
                end
            end
        end
        checks++;
        if (model_q.size() != 0 || out_valid !== 1'b0 || tx_count !== 16'(model_tx)) begin
            errors++;
            $display("FAIL random_final: got pending=%0d valid=%b tx=%0d want 0/0/%0d",
                     model_q.size(), out_valid, tx_count, model_tx);
        end
        $display("test_random done: transfers=%0d errors=%0d", model_tx, errors);
    endtask

    task automatic test_wrap();
        logic acc, emit;
        logic [2*W-1:0] got, exp;
        do_reset();
        for (int k = 0; k < 17; k++) step(1'b1, 8'($urandom), 8'($urandom), 1'b1, acc, emit, got, exp);
        step(1'b0, 8'h00, 8'h00, 1'b1, acc, emit, got, exp);
        checks++;
        if (tx_count_w !== 4'(model_tx % 16) || tx_count !== 16'(model_tx)) begin
            errors++;
            $display("FAIL wrap: got tx4=%0d tx16=%0d want %0d/%0d", tx_count_w, tx_count, model_tx % 16, model_tx);
        end
        $display("test_wrap done: tx4=%0d errors=%0d", tx_count_w, errors);
    endtask

    task automatic test_misr();
        logic acc, emit;
        logic [2*W-1:0] got, exp;
        logic [W-1:0] sig_exp;
        do_reset();
        for (int c = 0; c < 16 + D + 2; c++) begin
            step(c < 16, 8'(c), ~8'(c), 1'b1, acc, emit, got, exp);
`ifdef OB_SEQ_MISR_EN
            sig_exp = misr_m;
`else
            sig_exp = '0;
`endif
            checks++;
            if (sig !== sig_exp) begin
                errors++;
                $display("FAIL misr: cycle %0d got sig=%h want %h", c, sig, sig_exp);
            end
        end
        $display("test_misr done: sig=%h errors=%0d", sig, errors);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        i0        = '0;
        i1        = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_latency();
        test_stall();
        test_streaming();
        test_random();
        test_wrap();
        test_misr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
